// File: rtl/pistorm_txn_queue_pkg.sv
// Shared types for the Pi-to-68K transaction queue: issue states, queued entry layout,
// byte-lane decode and Pi register map offsets.
package pistorm_pkg;

  localparam int unsigned PKG_AW = 24;
  localparam int unsigned PKG_DW = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic [PKG_AW-1:0] addr;
    logic [PKG_DW-1:0] wdata;
    logic              rw;
    logic              uds_n;
    logic              lds_n;
  } entry_t;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // Returns {uds_n, lds_n}; even byte address lives on the upper lane.
  function automatic logic [1:0] lane_decode(input logic a0, input logic byte_acc);
    if (byte_acc) begin
      return {a0, !a0};
    end
    return 2'b00;
  endfunction

endpackage

// File: rtl/pistorm_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head entry is visible on o_data.
module pistorm_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

  // Equal index with differing wrap bit means the pointers are a full lap apart.
  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/pistorm_txn_queue.sv
// Queues Pi-issued 68K bus commands and hands them one at a time to the bus sequencer,
// capturing read data until the Pi acknowledges it.
module pistorm_txn_queue
  import pistorm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = PKG_AW,
  parameter int unsigned DW    = PKG_DW
) (
  input  logic                   PI_CLK,
  input  logic                   PI_RST_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [DW-1:0]          cmd_wdata,
  input  logic                   cmd_rw,
  input  logic                   cmd_byte,
  output logic                   op_req,
  output logic [AW-1:0]          op_addr,
  output logic [DW-1:0]          op_wdata,
  output logic                   op_rw,
  output logic                   op_uds_n,
  output logic                   op_lds_n,
  input  logic                   op_done,
  input  logic [DW-1:0]          op_rdata,
  output logic [DW-1:0]          rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ack,
  output logic                   txn_in_progress,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop_err,
  input  logic                   err_clr
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_t          r_state;
  logic            r_op_req;
  logic [AW-1:0]   r_op_addr;
  logic [DW-1:0]   r_op_wdata;
  logic            r_op_rw;
  logic            r_op_uds_n;
  logic            r_op_lds_n;
  logic [DW-1:0]   r_rd_data;
  logic            r_rd_valid;
  logic            r_drop_err;

  entry_t          w_entry;
  entry_t          w_head;
  logic [1:0]      w_lanes;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_issue;
  logic [LW-1:0]   w_level;

  assign w_lanes = lane_decode(cmd_addr[0], cmd_byte);

  always_comb begin
    w_entry       = '0;
    w_entry.addr  = cmd_addr;
    w_entry.wdata = cmd_wdata;
    w_entry.rw    = cmd_rw;
    w_entry.uds_n = w_lanes[1];
    w_entry.lds_n = w_lanes[0];
  end

  assign w_push = cmd_valid && !w_full;
  assign w_drop = cmd_valid && w_full;
  assign w_pop  = (r_state == ST_REQ) && op_done;
  // A queued read must not issue while the previous read result is still unread.
  assign w_issue = (r_state == ST_IDLE) && !w_empty && !(w_head.rw && r_rd_valid);

  pistorm_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (PI_CLK),
    .rst_n   (PI_RST_n),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge PI_CLK) begin
    if (!PI_RST_n) begin
      r_state    <= ST_IDLE;
      r_op_req   <= 1'b0;
      r_op_addr  <= '0;
      r_op_wdata <= '0;
      r_op_rw    <= 1'b1;
      r_op_uds_n <= 1'b1;
      r_op_lds_n <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state    <= ST_REQ;
            r_op_req   <= 1'b1;
            r_op_addr  <= w_head.addr;
            r_op_wdata <= w_head.wdata;
            r_op_rw    <= w_head.rw;
            r_op_uds_n <= w_head.uds_n;
            r_op_lds_n <= w_head.lds_n;
          end
        end
        ST_REQ: begin
          if (op_done) begin
            r_state    <= ST_IDLE;
            r_op_req   <= 1'b0;
            r_op_rw    <= 1'b1;
            r_op_uds_n <= 1'b1;
            r_op_lds_n <= 1'b1;
          end
        end
      endcase
    end
  end

  // Capture beats a same-cycle acknowledge so fresh data is never lost.
  always_ff @(posedge PI_CLK) begin
    if (!PI_RST_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_pop && r_op_rw) begin
      r_rd_data  <= op_rdata;
      r_rd_valid <= 1'b1;
    end else if (rd_ack) begin
      r_rd_valid <= 1'b0;
    end
  end

  always_ff @(posedge PI_CLK) begin
    if (!PI_RST_n) begin
      r_drop_err <= 1'b0;
    end else if (w_drop) begin
      r_drop_err <= 1'b1;
    end else if (err_clr) begin
      r_drop_err <= 1'b0;
    end
  end

  assign cmd_ready       = !w_full;
  assign op_req          = r_op_req;
  assign op_addr         = r_op_addr;
  assign op_wdata        = r_op_wdata;
  assign op_rw           = r_op_rw;
  assign op_uds_n        = r_op_uds_n;
  assign op_lds_n        = r_op_lds_n;
  assign rd_data         = r_rd_data;
  assign rd_valid        = r_rd_valid;
  assign drop_err        = r_drop_err;
  assign level           = w_level;
  assign txn_in_progress = !w_empty || (r_state == ST_REQ);

endmodule

// File: tb/tb_pistorm_txn_queue.sv
// Scoreboard bench: issued commands queue their expected bus request / read result,
// and a negedge monitor checks each one as the DUT presents it.
module tb_pistorm_txn_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 24;
  localparam int unsigned DW    = 16;

  logic          PI_CLK = 1'b0;
  logic          PI_RST_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_rw = 1'b0;
  logic          cmd_byte = 1'b0;
  logic          op_req;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;
  logic          op_rw;
  logic          op_uds_n;
  logic          op_lds_n;
  logic          op_done = 1'b0;
  logic [DW-1:0] op_rdata = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ack = 1'b0;
  logic          txn_in_progress;
  logic [2:0]    level;
  logic          drop_err;
  logic          err_clr = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rw;
    logic          uds_n;
    logic          lds_n;
  } exp_op_t;

  exp_op_t       exp_q[$];
  logic [DW-1:0] exp_rd_q[$];
  exp_op_t       mon_e;
  logic [DW-1:0] mon_rd;
  logic          prev_req = 1'b0;
  logic          prev_rv = 1'b0;
  int            total = 0;
  int            bad = 0;

  pistorm_txn_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .PI_CLK          (PI_CLK),
    .PI_RST_n        (PI_RST_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .cmd_rw          (cmd_rw),
    .cmd_byte        (cmd_byte),
    .op_req          (op_req),
    .op_addr         (op_addr),
    .op_wdata        (op_wdata),
    .op_rw           (op_rw),
    .op_uds_n        (op_uds_n),
    .op_lds_n        (op_lds_n),
    .op_done         (op_done),
    .op_rdata        (op_rdata),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ack          (rd_ack),
    .txn_in_progress (txn_in_progress),
    .level           (level),
    .drop_err        (drop_err),
    .err_clr         (err_clr)
  );

  always #5 PI_CLK = ~PI_CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PI_CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw,
                          input logic byt, input logic uds, input logic lds, input bit accept);
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_rw    = rw;
    cmd_byte  = byt;
    cmd_valid = 1'b1;
    if (accept) exp_q.push_back('{addr: a, wdata: d, rw: rw, uds_n: uds, lds_n: lds});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [DW-1:0] rdata);
    op_rdata = rdata;
    op_done  = 1'b1;
    tick();
    op_done  = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!op_req && n < 20) begin
      tick();
      n++;
    end
    check("wait_req", 32'(op_req), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_req"}, 32'(op_req), 32'd0);
    check({tag, "_op_rw"}, 32'(op_rw), 32'd1);
    check({tag, "_strobes"}, 32'({op_uds_n, op_lds_n}), 32'd3);
    check({tag, "_op_addr"}, 32'(op_addr), 32'd0);
    check({tag, "_op_wdata"}, 32'(op_wdata), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_drop_err"}, 32'(drop_err), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_txn"}, 32'(txn_in_progress), 32'd0);
  endtask

  // Monitor: compare each new bus request and each new read result against the scoreboard.
  always @(negedge PI_CLK) begin
    if (op_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req: got addr 0x%0h expected no request", op_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("req_addr", 32'(op_addr), 32'(mon_e.addr));
        check("req_wdata", 32'(op_wdata), 32'(mon_e.wdata));
        check("req_rw", 32'(op_rw), 32'(mon_e.rw));
        check("req_uds_n", 32'(op_uds_n), 32'(mon_e.uds_n));
        check("req_lds_n", 32'(op_lds_n), 32'(mon_e.lds_n));
      end
    end
    if (rd_valid && !prev_rv) begin
      if (exp_rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rd: got 0x%0h expected no read data", rd_data);
      end else begin
        mon_rd = exp_rd_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(mon_rd));
      end
    end
    prev_req = op_req;
    prev_rv  = rd_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tick();
    tick();
    check_reset_outputs("reset");
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    PI_RST_n = 1'b1;
    tick();

    // Word write: request exactly one cycle after the enqueue edge.
    send_cmd(24'hDFF180, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_req_not_yet", 32'(op_req), 32'd0);
    check("t1_level1", 32'(level), 32'd1);
    tick();
    check("t1_req_latency", 32'(op_req), 32'd1);
    pulse_done(16'h0000);
    check("t1_level0", 32'(level), 32'd0);
    check("t1_req_low", 32'(op_req), 32'd0);
    check("t1_txn_idle", 32'(txn_in_progress), 32'd0);

    // Odd-address byte read uses the lower lane.
    send_cmd(24'hBFE001, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_req();
    exp_rd_q.push_back(16'h00A5);
    pulse_done(16'h00A5);
    check("t2_rd_valid", 32'(rd_valid), 32'd1);
    check("t2_rd_data", 32'(rd_data), 32'h00A5);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("t2_rd_ack", 32'(rd_valid), 32'd0);

    // Fill to DEPTH, drop the overflow, exercise error flag priority and push+pop.
    for (int i = 0; i < 4; i++) begin
      send_cmd(24'h001000 + 24'(2 * i), 16'h1111 * 16'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("t3_cmd_ready_full", 32'(cmd_ready), 32'd0);
    check("t3_level_full", 32'(level), 32'd4);
    send_cmd(24'h002000, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_drop_err", 32'(drop_err), 32'd1);
    check("t3_level_after_drop", 32'(level), 32'd4);
    err_clr = 1'b1;
    send_cmd(24'h002002, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_set_wins", 32'(drop_err), 32'd1);
    tick();
    err_clr = 1'b0;
    check("t3_err_clr", 32'(drop_err), 32'd0);
    pulse_done(16'h0000);
    check("t3_level3", 32'(level), 32'd3);
    check("t3_req_gap", 32'(op_req), 32'd0);
    tick();
    check("t3_reissue", 32'(op_req), 32'd1);
    op_done = 1'b1;
    send_cmd(24'h003000, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    op_done = 1'b0;
    check("t3_push_pop_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      wait_req();
      pulse_done(16'h0000);
    end
    check("t3_drained", 32'(level), 32'd0);

    // Second read holds until the first result is acknowledged.
    send_cmd(24'h000100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_cmd(24'h000203, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_req();
    exp_rd_q.push_back(16'h1234);
    pulse_done(16'h1234);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold", 32'(op_req), 32'd0);
      tick();
    end
    check("t4_level1", 32'(level), 32'd1);
    check("t4_txn", 32'(txn_in_progress), 32'd1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("t4_ack_edge", 32'(op_req), 32'd0);
    tick();
    check("t4_issue_after_ack", 32'(op_req), 32'd1);
    exp_rd_q.push_back(16'hBEEF);
    rd_ack = 1'b1;
    pulse_done(16'hBEEF);
    rd_ack = 1'b0;
    check("t4_capture_wins", 32'(rd_valid), 32'd1);
    check("t4_rd_data", 32'(rd_data), 32'hBEEF);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;

    // Reset mid-transaction abandons it; the late done is ignored.
    send_cmd(24'h000010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_req();
    exp_rd_q.push_back(16'h5555);
    pulse_done(16'h5555);
    send_cmd(24'h00ABCD, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_req();
    PI_RST_n = 1'b0;
    tick();
    PI_RST_n = 1'b1;
    pulse_done(16'h9999);
    check_reset_outputs("t5");

    // Stray done while idle and empty leaves everything untouched.
    send_cmd(24'h000020, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_req();
    exp_rd_q.push_back(16'h00C3);
    pulse_done(16'h00C3);
    pulse_done(16'hFFFF);
    check("t6_level", 32'(level), 32'd0);
    check("t6_req", 32'(op_req), 32'd0);
    check("t6_rd_valid", 32'(rd_valid), 32'd1);
    check("t6_rd_data", 32'(rd_data), 32'h00C3);
    check("t6_txn", 32'(txn_in_progress), 32'd0);
    tick();
    tick();

    check("sb_req_empty", 32'(exp_q.size()), 32'd0);
    check("sb_rd_empty", 32'(exp_rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
